result_serializer: RTL and testbench

Output stage directly downstream of the 2x2 systolic array. It captures the four 16-bit accumulations (c00, c01, c10, c11) as one frame and streams them to the 8-bit host output bus, one byte per host read. Two modes: full-width raw (two bytes per element) or int8-quantized (arithmetic shift plus saturation, one byte per element). It replaces the direct byte-mux path between the accumulators and the output pins with a flow-controlled stream.

---
 rtl/tpu_pkg.sv | 11 +
 rtl/sat_quant.sv | 17 +
 rtl/result_serializer.sv | 73 +++++++
 tb/tb_result_serializer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: shared widths, FSM states and mode/byte-count constants for the output stage.
package tpu_pkg;
   localparam int ACC_W = 16;
   localparam int NUM_EL = 4;
   localparam int SHIFT_W = 4;
   localparam int BYTES_RAW = 8;
   localparam int BYTES_Q8 = 4;
   localparam logic MODE_RAW = 1'b0;
   localparam logic MODE_Q8 = 1'b1;
   typedef enum logic {IDLE, STREAM} state_t;
endpackage

// File: rtl/sat_quant.sv
// sat_quant: arithmetic right shift of a signed accumulation, saturated to int8.
module sat_quant
   import tpu_pkg::*;
(
   input  logic signed [ACC_W-1:0]   value,
   input  logic        [SHIFT_W-1:0] shift,
   output logic        [7:0]         q8,
   output logic                      sat_flag
);
   logic signed [ACC_W-1:0] sh;
   logic hi, lo;
   assign sh = value >>> shift;
   assign hi = sh > $signed(ACC_W'(127));
   assign lo = sh < $signed(ACC_W'(-128));
   assign q8 = hi ? 8'h7F : lo ? 8'h80 : sh[7:0];
   assign sat_flag = hi | lo;
endmodule

// File: rtl/result_serializer.sv
// result_serializer: captures a 2x2 result frame and streams it one byte per host read,
// either as raw 16-bit little-endian pairs or as saturated int8 values.
module result_serializer
   import tpu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               res_valid,
   input  logic [ACC_W-1:0]   c00,
   input  logic [ACC_W-1:0]   c01,
   input  logic [ACC_W-1:0]   c10,
   input  logic [ACC_W-1:0]   c11,
   input  logic               mode,
   input  logic [SHIFT_W-1:0] shift,
   input  logic               rd_en,
   output logic               res_ready,
   output logic [7:0]         data_out,
   output logic               data_valid,
   output logic               last,
   output logic               sat,
   output logic               dropped
);
   state_t state, nxt;
   logic [ACC_W-1:0] el [NUM_EL];
   logic [7:0] q8 [NUM_EL];
   logic [NUM_EL-1:0] flags;
   logic [ACC_W-1:0] cap [NUM_EL];
   logic [7:0] q_r [NUM_EL];
   logic mode_r, sat_r;
   logic [2:0] idx, last_idx;
   assign el[0] = c00;
   assign el[1] = c01;
   assign el[2] = c10;
   assign el[3] = c11;
   for (genvar i = 0; i < NUM_EL; i++) begin : g_q
      sat_quant u_q (.value(el[i]), .shift(shift), .q8(q8[i]), .sat_flag(flags[i]));
   end
   always_ff @(posedge clk)
      state <= rst ? IDLE : nxt;
   always_comb
      nxt = (state == IDLE) ? (res_valid ? STREAM : IDLE) : ((rd_en && last) ? IDLE : STREAM);
   always_comb begin
      res_ready = state == IDLE;
      data_valid = state == STREAM;
      last_idx = (mode_r == MODE_Q8) ? 3'(BYTES_Q8 - 1) : 3'(BYTES_RAW - 1);
      last = data_valid && idx == last_idx;
      data_out = (mode_r == MODE_Q8) ? q_r[idx[1:0]]
               : idx[0] ? cap[idx[2:1]][15:8] : cap[idx[2:1]][7:0];
      sat = sat_r;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cap <= '{default: '0};
         q_r <= '{default: '0};
         mode_r <= MODE_RAW;
         sat_r <= 1'b0;
         idx <= '0;
         dropped <= 1'b0;
      end else if (state == IDLE) begin
         if (res_valid) begin
            cap <= el;
            q_r <= q8;
            mode_r <= mode;
            sat_r <= (mode == MODE_Q8) && |flags;
            idx <= '0;
         end
      end else begin
         if (res_valid) dropped <= 1'b1;
         // index returns to 0 on the last byte so an idle block always shows byte 0
         if (rd_en) idx <= last ? 3'd0 : idx + 3'd1;
      end
   end
endmodule

// File: tb/tb_result_serializer.sv
// tb_result_serializer: directed checks of raw/quantized streaming, stalls, drops and resets.
module tb_result_serializer;
   logic clk = 1'b0, rst = 1'b1, res_valid = 1'b0, mode = 1'b0, rd_en = 1'b0;
   logic [15:0] c00 = '0, c01 = '0, c10 = '0, c11 = '0;
   logic [3:0] shift = '0;
   logic res_ready, data_valid, last, sat, dropped;
   logic [7:0] data_out;
   int vectors = 0, miscompares = 0;

   result_serializer dut (
      .clk(clk), .rst(rst), .res_valid(res_valid), .c00(c00), .c01(c01), .c10(c10), .c11(c11),
      .mode(mode), .shift(shift), .rd_en(rd_en), .res_ready(res_ready), .data_out(data_out),
      .data_valid(data_valid), .last(last), .sat(sat), .dropped(dropped)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic m, input logic [3:0] s, input logic [15:0] a, b, c, d);
      mode = m; shift = s; c00 = a; c01 = b; c10 = c; c11 = d;
      res_valid = 1'b1;
      tick();
      res_valid = 1'b0;
   endtask

   // bytes packed with byte 0 in the least significant position
   task automatic read_frame(input string tag, input int start, input int stop, input int total,
                             input logic [63:0] e, input logic s);
      for (int i = start; i < stop; i++) begin
         chk({tag, "_valid"}, 16'(data_valid), 16'd1);
         chk({tag, "_ready"}, 16'(res_ready), 16'd0);
         chk({tag, "_byte"}, 16'(data_out), 16'(e[8*i +: 8]));
         chk({tag, "_last"}, 16'(last), 16'(i == total - 1));
         chk({tag, "_sat"}, 16'(sat), 16'(s));
         rd_en = 1'b1;
         tick();
      end
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      chk("rst_ready", 16'(res_ready), 16'd1);
      chk("rst_valid", 16'(data_valid), 16'd0);
      chk("rst_data", 16'(data_out), 16'h00);
      chk("rst_last", 16'(last), 16'd0);
      chk("rst_sat", 16'(sat), 16'd0);
      chk("rst_drop", 16'(dropped), 16'd0);
      // reset beats a simultaneous frame
      rst = 1'b1; c00 = 16'hAAAA; res_valid = 1'b1;
      tick();
      rst = 1'b0; res_valid = 1'b0;
      chk("rstcap_valid", 16'(data_valid), 16'd0);
      chk("rstcap_data", 16'(data_out), 16'h00);
      // raw frame, continuous reads
      load(1'b0, 4'd0, 16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
      read_frame("raw", 0, 8, 8, 64'hFFFF_0001_ABCD_1234, 1'b0);
      rd_en = 1'b0;
      chk("raw_end_valid", 16'(data_valid), 16'd0);
      chk("raw_end_ready", 16'(res_ready), 16'd1);
      chk("raw_end_last", 16'(last), 16'd0);
      // quantized, shift 0
      load(1'b1, 4'd0, 16'h0064, 16'h00C8, 16'hFF38, 16'hFFF6);
      read_frame("q0", 0, 4, 4, 64'hF6_80_7F_64, 1'b1);
      rd_en = 1'b0;
      chk("q0_end_valid", 16'(data_valid), 16'd0);
      // quantized, shift 4
      load(1'b1, 4'd4, 16'h0640, 16'hF9C0, 16'h7FFF, 16'h000F);
      read_frame("q4", 0, 4, 4, 64'h00_7F_9C_64, 1'b1);
      rd_en = 1'b0;
      // stall with a dropped frame
      load(1'b0, 4'd0, 16'h0102, 16'h0304, 16'h0506, 16'h0708);
      read_frame("stl", 0, 2, 8, 64'h0708_0506_0304_0102, 1'b0);
      rd_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("stall_byte", 16'(data_out), 16'h04);
         chk("stall_valid", 16'(data_valid), 16'd1);
         if (k == 2) begin
            mode = 1'b1; c00 = 16'h7777; c01 = 16'h6666; res_valid = 1'b1;
         end
         tick();
         res_valid = 1'b0;
      end
      chk("drop_set", 16'(dropped), 16'd1);
      read_frame("stl", 2, 8, 8, 64'h0708_0506_0304_0102, 1'b0);
      rd_en = 1'b0;
      chk("drop_sticky", 16'(dropped), 16'd1);
      // reset mid-stream
      load(1'b0, 4'd0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      read_frame("mid", 0, 3, 8, 64'h4444_3333_2222_1111, 1'b0);
      rd_en = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_valid", 16'(data_valid), 16'd0);
      chk("mid_ready", 16'(res_ready), 16'd1);
      chk("mid_drop", 16'(dropped), 16'd0);
      load(1'b1, 4'd0, 16'h0005, 16'h0006, 16'h0007, 16'h0008);
      read_frame("post", 0, 4, 4, 64'h08_07_06_05, 1'b0);
      // reads in idle are ignored and leave the index at byte 0
      for (int k = 0; k < 3; k++) begin
         rd_en = k[0] ? 1'b0 : 1'b1;
         tick();
         chk("idle_valid", 16'(data_valid), 16'd0);
         chk("idle_data", 16'(data_out), 16'h05);
      end
      // back-to-back frames
      load(1'b0, 4'd0, 16'hBEEF, 16'hCAFE, 16'h0F0F, 16'h8001);
      read_frame("b2b1", 0, 8, 8, 64'h8001_0F0F_CAFE_BEEF, 1'b0);
      load(1'b1, 4'd1, 16'h0100, 16'hFE00, 16'h0010, 16'hFFFF);
      read_frame("b2b2", 0, 4, 4, 64'hFF_08_80_7F, 1'b1);
      rd_en = 1'b0;
      chk("b2b_end_valid", 16'(data_valid), 16'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
